// File: rtl/simple_pipeline_pkg.sv
// simple_pipeline_pkg: constants shared by the MAC pipeline, its drain controller and benches
package simple_pipeline_pkg;
  localparam int PIPE_LATENCY = 4;
  localparam int DEFAULT_WIDTH = 16;
  localparam int N_IN = 8;
  function automatic int ptr_w(int d);
    return d > 1 ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/simple_fifo_fwft.sv
// simple_fifo_fwft: first-word fall-through circular FIFO with any depth >= 1
module simple_fifo_fwft
  import simple_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
  assign rd_data = mem[rd_ptr];
  assign full = count == FULL;
  assign empty = count == '0;
endmodule

// File: rtl/simple_pipeline_with_en.sv
// simple_pipeline_with_en: 8-input pairwise multiply-accumulate pipeline, frozen whole while en is low
module simple_pipeline_with_en
  import simple_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  valid_in,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]      out,
  output logic                  valid_out
);
  logic [WIDTH-1:0] a [N_IN];
  logic [WIDTH-1:0] p [N_IN/2];
  logic [WIDTH-1:0] s [2];
  logic [WIDTH-1:0] t;
  logic [PIPE_LATENCY:0] v;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) a[i] <= '0;
      for (int i = 0; i < N_IN/2; i++) p[i] <= '0;
      s[0] <= '0;
      s[1] <= '0;
      t <= '0;
      out <= '0;
      v <= '0;
    end else if (en) begin
      for (int i = 0; i < N_IN; i++) a[i] <= in_data[i*WIDTH +: WIDTH];
      for (int i = 0; i < N_IN/2; i++) p[i] <= a[2*i] * a[2*i+1];
      s[0] <= p[0] + p[1];
      s[1] <= p[2] + p[3];
      t <= s[0] + s[1];
      out <= t;
      v <= {v[PIPE_LATENCY-1:0], valid_in};
    end
  end
  assign valid_out = v[PIPE_LATENCY];
endmodule

// File: rtl/simple_pipeline_drain.sv
// simple_pipeline_drain: buffers pipeline results in a FIFO and stalls the pipeline when it is full
module simple_pipeline_drain
  import simple_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       pipe_en,
  output logic                       pipe_valid_in,
  input  logic [WIDTH-1:0]           pipe_out,
  input  logic                       pipe_valid_out,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  logic full, empty, push, pop;
  // the held pipeline output is captured only on enabled cycles, so each result enters once
  assign pipe_en = !full;
  assign in_ready = pipe_en;
  assign pipe_valid_in = in_valid;
  assign push = pipe_valid_out && pipe_en;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  simple_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wr_data(pipe_out),
    .rd_data(out_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> (count < CW'(DEPTH)));
endmodule

// File: tb/tb_simple_pipeline_drain.sv
// tb_simple_pipeline_drain: drain+pipeline pairs at DEPTH 4 and 1 checked against a queue model
module tb_simple_pipeline_drain;
  import simple_pipeline_pkg::*;
  localparam int W = DEFAULT_WIDTH;
  typedef struct packed {
    logic [7:0][W-1:0] x;
    logic [W-1:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] in_valid = '0, out_ready = '0;
  logic [8*W-1:0] din_a = '0, din_b = '0;
  logic rdy_a, rdy_b, en_a, en_b, pvi_a, pvi_b, pvo_a, pvo_b, ov_a, ov_b;
  logic [W-1:0] pout_a, pout_b, od_a, od_b;
  logic [2:0] cnt_a;
  logic [0:0] cnt_b;
  int total = 0, bad = 0;
  int dep [2] = '{4, 1};
  logic [W-1:0] mq [2][$];
  logic pv [2][PIPE_LATENCY+1];
  logic [W-1:0] pd [2][PIPE_LATENCY+1];
  vec_t tv [6];
  always #5 clk = ~clk;
  simple_pipeline_drain #(.WIDTH(W), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy_a), .pipe_en(en_a),
    .pipe_valid_in(pvi_a), .pipe_out(pout_a), .pipe_valid_out(pvo_a), .out_data(od_a),
    .out_valid(ov_a), .out_ready(out_ready[0]), .count(cnt_a));
  simple_pipeline_with_en #(.WIDTH(W)) p_a (
    .clk(clk), .rst(rst), .en(en_a), .valid_in(pvi_a), .in_data(din_a), .out(pout_a), .valid_out(pvo_a));
  simple_pipeline_drain #(.WIDTH(W), .DEPTH(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy_b), .pipe_en(en_b),
    .pipe_valid_in(pvi_b), .pipe_out(pout_b), .pipe_valid_out(pvo_b), .out_data(od_b),
    .out_valid(ov_b), .out_ready(out_ready[1]), .count(cnt_b));
  simple_pipeline_with_en #(.WIDTH(W)) p_b (
    .clk(clk), .rst(rst), .en(en_b), .valid_in(pvi_b), .in_data(din_b), .out(pout_b), .valid_out(pvo_b));
  function automatic logic [W-1:0] mac(logic [8*W-1:0] x);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s = s + W'(x[2*k*W +: W] * x[(2*k+1)*W +: W]);
    return s;
  endfunction
  function automatic vec_t mk(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7, int e);
    vec_t v;
    v.x[0] = W'(a0); v.x[1] = W'(a1); v.x[2] = W'(a2); v.x[3] = W'(a3);
    v.x[4] = W'(a4); v.x[5] = W'(a5); v.x[6] = W'(a6); v.x[7] = W'(a7);
    v.exp = W'(e);
    return v;
  endfunction
  // reference: enable is "FIFO not full"; a result emerges after PIPE_LATENCY+1 enabled edges
  task automatic step(int d, logic r, logic iv, logic [8*W-1:0] x, logic ordy);
    logic en;
    en = mq[d].size() < dep[d];
    if (r) begin
      mq[d].delete();
      for (int i = 0; i <= PIPE_LATENCY; i++) pv[d][i] = 1'b0;
    end else begin
      if (mq[d].size() != 0 && ordy) void'(mq[d].pop_front());
      if (pv[d][PIPE_LATENCY] && en) mq[d].push_back(pd[d][PIPE_LATENCY]);
      if (en) begin
        for (int i = PIPE_LATENCY; i > 0; i--) begin
          pv[d][i] = pv[d][i-1];
          pd[d][i] = pd[d][i-1];
        end
        pv[d][0] = iv;
        pd[d][0] = mac(x);
      end
    end
  endtask
  always @(posedge clk) begin
    step(0, rst, in_valid[0], din_a, out_ready[0]);
    step(1, rst, in_valid[1], din_b, out_ready[1]);
  end
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic check_all();
    logic [31:0] g, e;
    logic [W-1:0] h;
    int sz;
    for (int d = 0; d < 2; d++) begin
      sz = mq[d].size();
      h = sz != 0 ? mq[d][0] : {W{1'b0}};
      g = d == 0 ? {12'(cnt_a), en_a, rdy_a, ov_a, pvi_a, ov_a ? od_a : {W{1'b0}}}
                 : {12'(cnt_b), en_b, rdy_b, ov_b, pvi_b, ov_b ? od_b : {W{1'b0}}};
      e = {12'(sz), sz < dep[d], sz < dep[d], sz != 0, in_valid[d], h};
      chk($sformatf("cycle_d%0d", d), 64'(g), 64'(e));
    end
  endtask
  task automatic tick();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    int lat, nval, sent, npop, nbadv, stale;
    logic [W-1:0] got;
    logic acc;
    tv[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 100);
    tv[1] = mk(1, 1, 1, 1, 1, 1, 1, 1, 4);
    tv[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[3] = mk(3, 5, 0, 9, 2, 2, 10, 10, 119);
    tv[4] = mk(255, 2, 0, 0, 0, 0, 0, 1, 510);
    tv[5] = mk(16'hffff, 16'hffff, 0, 0, 0, 0, 0, 0, 1);
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(ov_a), 0);
    chk("rst_count", 64'(cnt_a), 0);
    chk("rst_pipe_en", 64'(en_a), 1);
    chk("rst_in_ready", 64'(rdy_a), 1);
    chk("rst_out_data", 64'(od_a), 0);
    chk("rst_b_en", 64'(en_b), 1);
    for (int i = 0; i < 10; i++) tick();
    out_ready[0] = 1'b1;
    for (int v = 0; v < 6; v++) begin
      din_a = tv[v].x;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      lat = -1; nval = 0; got = '0;
      for (int k = 1; k <= 7; k++) begin
        tick();
        if (ov_a) begin
          nval++;
          if (lat < 0) begin lat = k; got = od_a; end
        end
      end
      chk($sformatf("vec%0d_latency", v), 64'(lat), 5);
      chk($sformatf("vec%0d_data", v), 64'(got), 64'(tv[v].exp));
      chk($sformatf("vec%0d_once", v), 64'(nval), 1);
    end
    out_ready[0] = 1'b0;
    din_a = tv[1].x;
    sent = 0;
    for (int c = 0; c < 60 && sent < 6; c++) begin
      in_valid[0] = 1'b1;
      acc = rdy_a;
      tick();
      if (acc) sent++;
    end
    in_valid[0] = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_sent", 64'(sent), 6);
    chk("bp_count_full", 64'(cnt_a), 4);
    chk("bp_pipe_en_low", 64'(en_a), 0);
    out_ready[0] = 1'b1;
    npop = 0; nbadv = 0;
    for (int i = 0; i < 20; i++) begin
      if (ov_a) begin
        npop++;
        if (od_a != 4) nbadv++;
      end
      tick();
    end
    chk("bp_outputs", 64'(npop), 6);
    chk("bp_values", 64'(nbadv), 0);
    for (int c = 0; c < 1000; c++) begin
      if (!(in_valid[0] && !rdy_a)) begin
        in_valid[0] = 1'($urandom);
        din_a = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!(in_valid[1] && !rdy_b)) begin
        in_valid[1] = 1'($urandom);
        din_b = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready[0] = 1'($urandom);
      out_ready[1] = ~out_ready[1];
      tick();
    end
    in_valid = '0;
    out_ready = '1;
    for (int i = 0; i < 20; i++) tick();
    chk("drain_a_empty", 64'(cnt_a), 0);
    chk("drain_b_empty", 64'(cnt_b), 0);
    out_ready = '0;
    din_a = tv[0].x;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    in_valid[0] = 1'b0;
    for (int c = 0; c < 20 && cnt_a != 3; c++) tick();
    chk("mid_count3", 64'(cnt_a), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 64'(ov_a), 0);
    chk("mid_rst_count", 64'(cnt_a), 0);
    out_ready = '1;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ov_a) stale++;
    end
    chk("mid_no_stale", 64'(stale), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
